// File: rtl/ldo_pkg.sv
// Shared definitions for the LDO handover datapath.
//   NSEG / CW     : default segment count per DLDO bank and count width
//   state_t       : slewer FSM states
//   cnt_to_therm_n: binary count -> active-low thermometer (bit 0 first ON)
package ldo_pkg;

   localparam int unsigned NSEG = 64;
   localparam int unsigned CW   = 7;

   typedef enum logic {
      IDLE = 1'b0,
      SLEW = 1'b1
   } state_t;

   function automatic logic [NSEG-1:0] cnt_to_therm_n(input logic [CW-1:0] cnt);
      logic [NSEG-1:0] t;
      for (int unsigned i = 0; i < NSEG; i++) begin
         t[i] = (CW'(i) >= cnt);
      end
      return t;
   endfunction

endpackage

// File: rtl/seg_bank_slew.sv
// One DLDO bank: holds the current and latched target segment counts and the
// registered active-low thermometer enable bus, and performs one step per
// strobe toward the target.
//   clk, rst : clock, synchronous active-high reset
//   ld       : latch ld_tgt (saturated to NSEG) as the new target
//   ld_tgt   : raw target count
//   step     : step strobe from the shared divider
//   hold_up  : some bank still has to turn segments off; suppress increments
//   en_n     : segment enables, 0 = ON
//   dn_req   : this bank has segments to turn off
//   ld_clip  : ld_tgt exceeds NSEG
//   ld_eq    : saturated ld_tgt equals the current count
//   nxt_eq   : count after this cycle's step equals the current target
module seg_bank_slew
   import ldo_pkg::*;
#(
   parameter int unsigned NSEG = ldo_pkg::NSEG,
   parameter int unsigned CW   = ldo_pkg::CW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ld,
   input  logic [CW-1:0]   ld_tgt,
   input  logic            step,
   input  logic            hold_up,
   output logic [NSEG-1:0] en_n,
   output logic            dn_req,
   output logic            ld_clip,
   output logic            ld_eq,
   output logic            nxt_eq
);

   localparam logic [CW-1:0] NSEG_C = CW'(NSEG);

   logic [CW-1:0] cur;
   logic [CW-1:0] tgt;
   logic [CW-1:0] tgt_sat;
   logic [CW-1:0] cur_nxt;
   logic          up_req;

   assign ld_clip = (ld_tgt > NSEG_C);
   assign tgt_sat = ld_clip ? NSEG_C : ld_tgt;
   assign ld_eq   = (tgt_sat == cur);

   // tgt never exceeds NSEG, so the compares also bound cur to [0, NSEG]
   assign dn_req  = (cur > tgt);
   assign up_req  = (cur < tgt);

   always_comb begin
      cur_nxt = cur;
      if (step && dn_req) begin
         cur_nxt = cur - CW'(1);
      end else if (step && up_req && !hold_up) begin
         cur_nxt = cur + CW'(1);
      end
   end

   assign nxt_eq = (cur_nxt == tgt);

   always_ff @(posedge clk) begin
      if (rst) begin
         cur  <= '0;
         tgt  <= '0;
         en_n <= '1;
      end else begin
         cur  <= cur_nxt;
         en_n <= cnt_to_therm_n(cur_nxt);
         if (ld) begin
            tgt <= tgt_sat;
         end
      end
   end

endmodule

// File: rtl/dldo_seg_slewer.sv
// Slews the two DLDO segment enable buses toward latched per-bank targets,
// one segment per programmable tick, turning segments off in every bank
// before any bank is allowed to turn segments on.
//   clk, rst        : clock, synchronous active-high reset
//   i_div           : tick period minus 1 (clk cycles), sampled on reload
//   i_tgt0/1_cnt    : per-bank target count of ON segments
//   i_tgt_valid     : target update strobe; o_tgt_ready = ~i_freeze
//   i_freeze        : hold all slewing state
//   o_dldo0/1_en_n  : active-low thermometer enables
//   o_busy          : slewing in progress
//   o_settled       : one-cycle pulse when outputs reach the targets
//   o_clip          : one-cycle pulse when an accepted target exceeded NSEG
module dldo_seg_slewer
   import ldo_pkg::*;
#(
   parameter int unsigned NSEG  = ldo_pkg::NSEG,
   parameter int unsigned CW    = ldo_pkg::CW,
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] i_div,
   input  logic [CW-1:0]    i_tgt0_cnt,
   input  logic [CW-1:0]    i_tgt1_cnt,
   input  logic             i_tgt_valid,
   output logic             o_tgt_ready,
   input  logic             i_freeze,
   output logic [NSEG-1:0]  o_dldo0_en_n,
   output logic [NSEG-1:0]  o_dldo1_en_n,
   output logic             o_busy,
   output logic             o_settled,
   output logic             o_clip
);

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic             settled_nxt;
   logic             clip_nxt;
   logic             accept;
   logic             step;
   logic             hold_up;
   logic             dn0, dn1;
   logic             clip0, clip1;
   logic             ld_eq0, ld_eq1;
   logic             nxt_eq0, nxt_eq1;

   assign o_tgt_ready = ~i_freeze;
   assign accept      = i_tgt_valid & o_tgt_ready;
   assign step        = (state == SLEW) && !i_freeze && (div_cnt == '0);
   assign hold_up     = dn0 | dn1;
   assign o_busy      = (state == SLEW);

   seg_bank_slew #(.NSEG(NSEG), .CW(CW)) u_bank0 (
      .clk     (clk),
      .rst     (rst),
      .ld      (accept),
      .ld_tgt  (i_tgt0_cnt),
      .step    (step),
      .hold_up (hold_up),
      .en_n    (o_dldo0_en_n),
      .dn_req  (dn0),
      .ld_clip (clip0),
      .ld_eq   (ld_eq0),
      .nxt_eq  (nxt_eq0)
   );

   seg_bank_slew #(.NSEG(NSEG), .CW(CW)) u_bank1 (
      .clk     (clk),
      .rst     (rst),
      .ld      (accept),
      .ld_tgt  (i_tgt1_cnt),
      .step    (step),
      .hold_up (hold_up),
      .en_n    (o_dldo1_en_n),
      .dn_req  (dn1),
      .ld_clip (clip1),
      .ld_eq   (ld_eq1),
      .nxt_eq  (nxt_eq1)
   );

   always_comb begin
      state_nxt   = state;
      div_nxt     = div_cnt;
      settled_nxt = 1'b0;
      clip_nxt    = accept & (clip0 | clip1);
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (!(ld_eq0 && ld_eq1)) begin
                  state_nxt = SLEW;
                  div_nxt   = i_div;
               end else begin
                  settled_nxt = 1'b1;
               end
            end
         end
         SLEW: begin
            if (!i_freeze) begin
               div_nxt = (div_cnt == '0) ? i_div : div_cnt - DIV_W'(1);
               // nxt_eq compares against the target being replaced on an
               // accept edge, so the exit check waits for the new target.
               if (!accept && nxt_eq0 && nxt_eq1) begin
                  state_nxt   = IDLE;
                  settled_nxt = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         div_cnt   <= '0;
         o_settled <= 1'b0;
         o_clip    <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_nxt;
         o_settled <= settled_nxt;
         o_clip    <= clip_nxt;
      end
   end

endmodule

// File: tb/tb_dldo_seg_slewer.sv
module tb_dldo_seg_slewer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  i_div;
   logic [6:0]  i_tgt0_cnt, i_tgt1_cnt;
   logic        i_tgt_valid;
   logic        o_tgt_ready;
   logic        i_freeze;
   logic [63:0] o_dldo0_en_n, o_dldo1_en_n;
   logic        o_busy, o_settled, o_clip;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dldo_seg_slewer #(.NSEG(64), .CW(7), .DIV_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_div        (i_div),
      .i_tgt0_cnt   (i_tgt0_cnt),
      .i_tgt1_cnt   (i_tgt1_cnt),
      .i_tgt_valid  (i_tgt_valid),
      .o_tgt_ready  (o_tgt_ready),
      .i_freeze     (i_freeze),
      .o_dldo0_en_n (o_dldo0_en_n),
      .o_dldo1_en_n (o_dldo1_en_n),
      .o_busy       (o_busy),
      .o_settled    (o_settled),
      .o_clip       (o_clip)
   );

   typedef struct {
      int t0;
      int t1;
      int dv;
      int exp_c0;
      int exp_c1;
      int exp_n;
      bit exp_clip;
   } vec_t;

   vec_t vt[9];

   function automatic logic [63:0] therm(input int c);
      logic [64:0] m;
      m = (65'd1 << c) - 65'd1;
      return ~m[63:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic accept(input int t0, input int t1, input int dv);
      i_tgt0_cnt  = 7'(t0);
      i_tgt1_cnt  = 7'(t1);
      i_div       = 8'(dv);
      i_tgt_valid = 1'b1;
      step();
      i_tgt_valid = 1'b0;
   endtask

   task automatic wait_settled(input int limit, output int n);
      n = 0;
      while (!o_settled && n < limit) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;

      vt[0] = '{5,   3,   0, 5,  3,  5,   1'b0};
      vt[1] = '{10,  0,   1, 10, 0,  16,  1'b0};
      vt[2] = '{6,   4,   3, 6,  4,  32,  1'b0};
      vt[3] = '{6,   4,   0, 6,  4,  0,   1'b0};
      vt[4] = '{100, 2,   0, 64, 2,  60,  1'b1};
      vt[5] = '{0,   0,   2, 0,  0,  192, 1'b0};
      vt[6] = '{127, 127, 0, 64, 64, 64,  1'b1};
      vt[7] = '{64,  64,  5, 64, 64, 0,   1'b0};
      vt[8] = '{1,   0,   0, 1,  0,  64,  1'b0};

      rst = 1'b1; i_div = '0; i_tgt0_cnt = '0; i_tgt1_cnt = '0;
      i_tgt_valid = 1'b0; i_freeze = 1'b0;
      @(negedge clk);
      step();
      step();
      chk("rst_en0",     o_dldo0_en_n, '1);
      chk("rst_en1",     o_dldo1_en_n, '1);
      chk("rst_busy",    64'(o_busy), 64'd0);
      chk("rst_settled", 64'(o_settled), 64'd0);
      chk("rst_clip",    64'(o_clip), 64'd0);
      chk("rst_ready",   64'(o_tgt_ready), 64'd1);
      rst = 1'b0;
      step();

      // Table: each vector starts from where the previous one settled.
      for (int i = 0; i < 9; i++) begin
         accept(vt[i].t0, vt[i].t1, vt[i].dv);
         chk($sformatf("v%0d_clip", i), 64'(o_clip), 64'(vt[i].exp_clip));
         chk($sformatf("v%0d_busy", i), 64'(o_busy), 64'(vt[i].exp_n > 0));
         wait_settled(400, n);
         chk($sformatf("v%0d_cycles", i), 64'(n), 64'(vt[i].exp_n));
         chk($sformatf("v%0d_en0", i), o_dldo0_en_n, therm(vt[i].exp_c0));
         chk($sformatf("v%0d_en1", i), o_dldo1_en_n, therm(vt[i].exp_c1));
         chk($sformatf("v%0d_busy_end", i), 64'(o_busy), 64'd0);
         step();
         chk($sformatf("v%0d_settled_pulse", i), 64'(o_settled), 64'd0);
         chk($sformatf("v%0d_clip_pulse", i), 64'(o_clip), 64'd0);
      end

      // Break-before-make, cur (10,0) -> (6,4) with 4-cycle tick.
      accept(10, 0, 0);
      wait_settled(100, n);
      chk("bbm_setup", o_dldo0_en_n, therm(10));
      step();
      accept(6, 4, 3);
      for (int e = 1; e <= 32; e++) begin
         int j, c0, c1;
         step();
         j  = e / 4;
         c0 = (j <= 4) ? 10 - j : 6;
         c1 = (j <= 4) ? 0 : j - 4;
         chk($sformatf("bbm_en0_e%0d", e), o_dldo0_en_n, therm(c0));
         chk($sformatf("bbm_en1_e%0d", e), o_dldo1_en_n, therm(c1));
         chk($sformatf("bbm_settled_e%0d", e), 64'(o_settled), 64'(e == 32));
      end
      step();

      // Freeze mid-slew from (6,4) toward (20,4), tick 4.
      accept(20, 4, 3);
      for (int e = 1; e <= 6; e++) step();
      chk("frz_pre_en0", o_dldo0_en_n, therm(7));
      i_freeze = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step();
         chk("frz_en0",   o_dldo0_en_n, therm(7));
         chk("frz_en1",   o_dldo1_en_n, therm(4));
         chk("frz_busy",  64'(o_busy), 64'd1);
         chk("frz_ready", 64'(o_tgt_ready), 64'd0);
      end
      i_freeze = 1'b0;
      step();
      chk("frz_resume1", o_dldo0_en_n, therm(7));
      step();
      chk("frz_resume2", o_dldo0_en_n, therm(8));

      // Retarget to the current count while slewing up.
      accept(8, 4, 3);
      chk("rt_busy0",    64'(o_busy), 64'd1);
      chk("rt_settled0", 64'(o_settled), 64'd0);
      step();
      chk("rt_settled1", 64'(o_settled), 64'd1);
      chk("rt_busy1",    64'(o_busy), 64'd0);
      for (int e = 0; e < 5; e++) begin
         step();
         chk("rt_hold_en0", o_dldo0_en_n, therm(8));
         chk("rt_hold_settled", 64'(o_settled), 64'd0);
      end

      // Reset during slew at cur0 = 30.
      accept(40, 4, 0);
      for (int e = 1; e <= 22; e++) step();
      chk("rs_pre_en0",  o_dldo0_en_n, therm(30));
      chk("rs_pre_busy", 64'(o_busy), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rs_en0",     o_dldo0_en_n, '1);
      chk("rs_en1",     o_dldo1_en_n, '1);
      chk("rs_busy",    64'(o_busy), 64'd0);
      chk("rs_settled", 64'(o_settled), 64'd0);
      for (int e = 0; e < 3; e++) begin
         step();
         chk("rs_idle_en0",     o_dldo0_en_n, '1);
         chk("rs_idle_settled", 64'(o_settled), 64'd0);
      end
      accept(1, 0, 0);
      chk("rs_acc_busy", 64'(o_busy), 64'd1);
      chk("rs_acc_en0",  o_dldo0_en_n, '1);
      step();
      chk("rs_step_en0",    o_dldo0_en_n, therm(1));
      chk("rs_step_en1",    o_dldo1_en_n, '1);
      chk("rs_step_settle", 64'(o_settled), 64'd1);
      chk("rs_step_busy",   64'(o_busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
